// File: rtl/fds_audio_lpf_mix.sv
// fds_audio_lpf_mix: one-pole RC low-pass on the FDS level, mixed with the APU into a saturated 16-bit output
// Ports: clk/reset (async, active-high); m2 = CPU M2, decimated to the filter sample rate;
// enable = 1 filters, 0 bypasses; fds_in = 12-bit FDS level; apu_in = 16-bit APU mix;
// fds_filt = filtered level (accumulator high half); sample_strobe = pulse after each update;
// mix_out = registered min(apu_in + (fds_filt >> FDS_SHIFT), 0xFFFF).
module fds_audio_lpf_mix #(
  parameter int DIV = 4,
  parameter logic [15:0] COEF = 16'd1817,
  parameter int FDS_SHIFT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m2,
  input  logic        enable,
  input  logic [11:0] fds_in,
  input  logic [15:0] apu_in,
  output logic [15:0] fds_filt,
  output logic        sample_strobe,
  output logic [15:0] mix_out
);
  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;
  state_t state;
  logic m2_d, trig, pending, sign;
  logic [7:0] div_cnt;
  logic [3:0] bit_cnt;
  logic [15:0] x, y_hi, mag, mcand;
  logic [31:0] y_acc, prod, addend, y_next;
  logic [32:0] sum;
  logic [16:0] mix_sum;
  logic rise, last_div;
  assign x = {fds_in, 4'b0};
  assign y_hi = y_acc[31:16];
  assign fds_filt = y_hi;
  assign rise = m2 & ~m2_d;
  assign last_div = div_cnt == 8'(DIV - 1);
  assign addend = mcand[0] ? {16'b0, mag} << bit_cnt : '0;
  assign sum = {1'b0, y_acc} + {1'b0, prod};
  // Clamp both directions so the accumulator never wraps.
  assign y_next = sign ? (prod > y_acc ? '0 : y_acc - prod) : (sum[32] ? '1 : sum[31:0]);
  assign mix_sum = {1'b0, apu_in} + {1'b0, fds_filt >> FDS_SHIFT};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m2_d <= 1'b0;
      div_cnt <= '0;
      trig <= 1'b0;
      mix_out <= '0;
    end else begin
      m2_d <= m2;
      if (rise) div_cnt <= last_div ? '0 : div_cnt + 8'd1;
      trig <= rise & last_div;
      mix_out <= mix_sum[16] ? 16'hFFFF : mix_sum[15:0];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      y_acc <= '0;
      pending <= 1'b0;
      sample_strobe <= 1'b0;
      sign <= 1'b0;
      mag <= '0;
      mcand <= '0;
      prod <= '0;
      bit_cnt <= '0;
    end else if (!enable) begin
      y_acc <= {x, 16'b0};
      state <= IDLE;
      pending <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= state == ACC;
      case (state)
        IDLE: if (trig | pending) begin
          sign <= x < y_hi;
          mag <= x < y_hi ? y_hi - x : x - y_hi;
          mcand <= COEF;
          prod <= '0;
          bit_cnt <= '0;
          // A trig landing on the same cycle a pending one is consumed becomes the new pending.
          pending <= pending & trig;
          state <= MUL;
        end
        MUL: begin
          prod <= prod + addend;
          mcand <= mcand >> 1;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) state <= ACC;
          if (trig) pending <= 1'b1;
        end
        ACC: begin
          y_acc <= y_next;
          state <= IDLE;
          if (trig) pending <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fds_audio_lpf_mix.sv
// tb_fds_audio_lpf_mix: scoreboard bench for the FDS low-pass/mix stage
module tb_fds_audio_lpf_mix;
  logic clk = 1'b0, reset = 1'b1, m2 = 1'b0, enable = 1'b1;
  logic [11:0] fds_in = '0;
  logic [15:0] apu_in = '0;
  logic [15:0] fds_filt, mix_out;
  logic sample_strobe;
  typedef struct {int val; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;
  int errors = 0, checks = 0, cyc = 0, edges = 0, dir = 0, last = 0, s = 0, cb = 0;
  bit prev_strobe = 1'b0;
  longint y = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fds_audio_lpf_mix dut (
    .clk(clk), .reset(reset), .m2(m2), .enable(enable), .fds_in(fds_in),
    .apu_in(apu_in), .fds_filt(fds_filt), .sample_strobe(sample_strobe), .mix_out(mix_out)
  );
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction
  // Reference filter: y += k*(x - y_hi), clamped to the 32-bit range.
  function automatic int step(input logic [11:0] f);
    longint xv, yh, p;
    xv = longint'(f) << 4;
    yh = y >> 16;
    if (xv < yh) begin
      p = (yh - xv) * 1817;
      y = p > y ? 0 : y - p;
    end else begin
      p = (xv - yh) * 1817;
      y = y + p;
      if (y > 64'hFFFF_FFFF) y = 64'hFFFF_FFFF;
    end
    return int'(y >> 16);
  endfunction
  always @(negedge clk) begin
    if (reset) prev_strobe = 1'b0;
    else begin
      if (sample_strobe) begin
        chk("strobe_width", {31'b0, prev_strobe}, 0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: fds_filt=%0h but no sample was expected", fds_filt);
        end else begin
          e = q.pop_front();
          chk("fds_filt", {16'b0, fds_filt}, e.val);
          if (e.cyc >= 0) chk("strobe_latency", cyc, e.cyc);
          if (dir > 0) chk("monotonic_up", {31'b0, int'(fds_filt) >= last}, 1);
          if (dir < 0) chk("monotonic_down", {31'b0, int'(fds_filt) <= last}, 1);
        end
        last = int'(fds_filt);
      end
      if (prev_strobe) begin
        s = int'(apu_in) + (last >> 1);
        chk("mix_out", {16'b0, mix_out}, s > 65535 ? 65535 : s);
      end
      prev_strobe = sample_strobe;
    end
  end
  task automatic m2_edge(input int hi, input int lo, input bit push);
    m2 = 1'b1;
    edges++;
    if (push && enable && edges % 4 == 0) q.push_back('{step(fds_in), cyc + 19});
    repeat (hi) @(negedge clk);
    m2 = 1'b0;
    repeat (lo) @(negedge clk);
  endtask
  task automatic samples(input int n, input int hi, input int lo);
    repeat (n * 4) m2_edge(hi, lo, 1'b1);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_fds_filt", {16'b0, fds_filt}, 0);
    chk("reset_mix_out", {16'b0, mix_out}, 0);
    chk("reset_strobe", {31'b0, sample_strobe}, 0);
    reset = 1'b0;
    fds_in = 12'hFFF;
    dir = 1;
    samples(1, 6, 6);
    drain();
    chk("step_first", {16'b0, fds_filt}, 16'h0718);
    samples(4, 6, 6);
    samples(295, 3, 3);
    drain();
    chk("step_reach_F000", {31'b0, fds_filt >= 16'hF000}, 1);
    apu_in = 16'h1234;
    cb = cyc + 6;
    q.push_back('{step(fds_in), cb + 19});
    q.push_back('{step(fds_in), cb + 37});
    repeat (12) m2_edge(1, 1, 1'b0);
    repeat (60) @(negedge clk);
    drain();
    samples(1, 3, 3);
    drain();
    dir = -1;
    fds_in = 12'h000;
    samples(600, 3, 3);
    drain();
    chk("settle_zero", {16'b0, fds_filt}, 0);
    dir = 0;
    enable = 1'b0;
    fds_in = 12'h800;
    @(negedge clk);
    chk("bypass_fds_filt", {16'b0, fds_filt}, 16'h8000);
    y = longint'(32'h8000_0000);
    apu_in = 16'hF000;
    @(negedge clk);
    chk("bypass_mix_sat", {16'b0, mix_out}, 16'hFFFF);
    apu_in = 16'h1000;
    @(negedge clk);
    chk("bypass_mix", {16'b0, mix_out}, 16'h5000);
    repeat (8) m2_edge(3, 3, 1'b1);
    repeat (30) @(negedge clk);
    fds_in = 12'hFFF;
    enable = 1'b1;
    apu_in = 16'h0000;
    samples(1, 3, 3);
    drain();
    chk("enable_rise_first", {16'b0, fds_filt}, 16'h838C);
    samples(3, 3, 3);
    drain();
    repeat (4) m2_edge(3, 3, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_fds_filt", {16'b0, fds_filt}, 0);
    chk("async_rst_mix_out", {16'b0, mix_out}, 0);
    chk("async_rst_strobe", {31'b0, sample_strobe}, 0);
    q.delete();
    y = 0;
    @(negedge clk);
    reset = 1'b0;
    edges = 0;
    repeat (3) m2_edge(3, 3, 1'b1);
    repeat (40) @(negedge clk);
    m2_edge(3, 3, 1'b1);
    drain();
    chk("post_reset_first", {16'b0, fds_filt}, 16'h0718);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
